// File: rtl/sseg_pkg.sv
// Shared constants for the multiplexed seven-segment display driver.
package sseg_pkg;

    localparam logic [7:0] SSEG_BLANK = 8'hFF;

    // Active-low g..a patterns for hex digits 0-F
    localparam logic [6:0] SEG_LUT [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0] SEG_OFF = 7'h7F;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex nibble + decimal point to active-low segment pattern.
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       dp,
    output logic [7:0] sseg_c
);

    assign sseg_c = {~dp, SEG_LUT[hex]};

endmodule

// File: rtl/sseg_mux_n.sv
// N-digit multiplexed seven-segment driver with frame-atomic value updates.
// Optional leading-zero blanking is enabled by defining SSEG_LZ_BLANK_EN.
module sseg_mux_n
    import sseg_pkg::*;
#(
    parameter int unsigned N_DIGITS   = 4,
    parameter int unsigned PRESC_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] hex_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    output logic                  busy,
    output logic [N_DIGITS-1:0]   an,
    output logic [7:0]            sseg
);

    localparam int unsigned IDX_W = idx_width(N_DIGITS);
    localparam int unsigned HEX_W = 4 * N_DIGITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

    logic [PRESC_BITS-1:0] presc;
    logic [IDX_W-1:0]      idx;
    logic                  running;
    logic [HEX_W-1:0]      pend_hex;
    logic [N_DIGITS-1:0]   pend_dp;
    logic [HEX_W-1:0]      disp_hex;
    logic [N_DIGITS-1:0]   disp_dp;

    logic                  tick;
    logic                  boundary;
    logic                  commit;
    logic [IDX_W-1:0]      idx_nxt;
    logic [HEX_W-1:0]      disp_hex_nxt;
    logic [N_DIGITS-1:0]   disp_dp_nxt;
    logic [3:0]            nib_c;
    logic                  dp_c;
    logic                  blank_c;
    logic [7:0]            pat_c;
    logic [7:0]            seg_nxt;
    logic [N_DIGITS-1:0]   an_nxt;

    assign tick     = &presc;
    assign boundary = tick & running & (idx == LAST_IDX);
    assign commit   = boundary & busy;

    // First tick after reset lights digit 0 without advancing; later ticks step and wrap.
    always_comb begin
        idx_nxt = idx;
        if (tick && running) begin
            idx_nxt = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        end
    end

    // Output registers are loaded from the post-commit value so a new frame is never mixed.
    assign disp_hex_nxt = commit ? pend_hex : disp_hex;
    assign disp_dp_nxt  = commit ? pend_dp  : disp_dp;
    assign nib_c        = disp_hex_nxt[{idx_nxt, 2'b00} +: 4];
    assign dp_c         = disp_dp_nxt[idx_nxt];
    assign an_nxt       = ~(N_DIGITS'(1) << idx_nxt);

`ifdef SSEG_LZ_BLANK_EN
    assign blank_c = (idx_nxt != '0) && ((disp_hex_nxt >> {idx_nxt, 2'b00}) == '0);
`else
    assign blank_c = 1'b0;
`endif

    hex_to_sseg u_dec (
        .hex    (nib_c),
        .dp     (dp_c),
        .sseg_c (pat_c)
    );

    assign seg_nxt = blank_c ? {pat_c[7], SEG_OFF} : pat_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc    <= '0;
            idx      <= '0;
            running  <= 1'b0;
            pend_hex <= '0;
            pend_dp  <= '0;
            disp_hex <= '0;
            disp_dp  <= '0;
            busy     <= 1'b0;
            an       <= '1;
            sseg     <= SSEG_BLANK;
        end else begin
            presc <= presc + PRESC_BITS'(1);
            if (tick) begin
                idx     <= idx_nxt;
                running <= 1'b1;
                an      <= an_nxt;
                sseg    <= seg_nxt;
            end
            if (commit) begin
                disp_hex <= pend_hex;
                disp_dp  <= pend_dp;
            end
            if (load) begin
                pend_hex <= hex_in;
                pend_dp  <= dp_in;
                busy     <= 1'b1;
            end else if (boundary) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sseg_mux_n.sv
// Directed self-checking bench for sseg_mux_n (N_DIGITS=4, PRESC_BITS=2).
module tb_sseg_mux_n;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] hex_in;
    logic [3:0]  dp_in;
    logic        busy;
    logic [3:0]  an;
    logic [7:0]  sseg;

    int n_cmp = 0;
    int n_err = 0;

    always #10 clk = ~clk;

    sseg_mux_n #(.N_DIGITS(4), .PRESC_BITS(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .hex_in (hex_in),
        .dp_in  (dp_in),
        .busy   (busy),
        .an     (an),
        .sseg   (sseg)
    );

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_disp(input string tag, input logic [3:0] exp_an,
                              input logic [7:0] exp_seg);
        check({tag, ".an"},   16'(an),   16'(exp_an));
        check({tag, ".sseg"}, 16'(sseg), 16'(exp_seg));
    endtask

    task automatic do_load(input logic [15:0] h, input logic [3:0] d);
        hex_in = h;
        dp_in  = d;
        load   = 1'b1;
        adv(1);
        load   = 1'b0;
    endtask

    // Edge numbering: P1 is the first rising edge after reset release.
    initial begin
        reset  = 1'b1;
        load   = 1'b0;
        hex_in = '0;
        dp_in  = '0;
        adv(2);
        check_disp("rst_hold", 4'hF, 8'hFF);
        check("rst_busy", 16'(busy), 16'h0);
        reset = 1'b0;
        adv(3);
        check_disp("pre_tick", 4'hF, 8'hFF);
        adv(1);                                 // after P4: first tick shows digit 0
        check_disp("first_tick", 4'b1110, 8'hC0);

        // Scan of 1234, committed at P20
        do_load(16'h1234, 4'b0000);             // P5
        check("scan_busy", 16'(busy), 16'h1);
        adv(15);                                // P20
        check_disp("scan_d0", 4'b1110, 8'h99);
        check("scan_busy_clr", 16'(busy), 16'h0);
        adv(4);
        check_disp("scan_d1", 4'b1101, 8'hB0);
        adv(4);
        check_disp("scan_d2", 4'b1011, 8'hA4);
        adv(4);
        check_disp("scan_d3", 4'b0111, 8'hF9);
        adv(4);                                 // P36
        check_disp("scan_wrap", 4'b1110, 8'h99);

        // Atomic update mid-frame
        adv(4);                                 // P40
        do_load(16'hABCD, 4'b0000);             // P41
        check("atom_busy", 16'(busy), 16'h1);
        adv(3);                                 // P44
        check_disp("atom_old_d2", 4'b1011, 8'hA4);
        adv(4);                                 // P48
        check_disp("atom_old_d3", 4'b0111, 8'hF9);
        check("atom_busy_hold", 16'(busy), 16'h1);
        adv(4);                                 // P52
        check_disp("atom_d0", 4'b1110, 8'hA1);
        check("atom_busy_clr", 16'(busy), 16'h0);
        adv(4);
        check_disp("atom_d1", 4'b1101, 8'hC6);
        adv(4);
        check_disp("atom_d2", 4'b1011, 8'h83);
        adv(4);                                 // P64
        check_disp("atom_d3", 4'b0111, 8'h88);

        // Overwrite within a frame
        adv(4);                                 // P68
        do_load(16'h1111, 4'b0000);             // P69
        do_load(16'h2222, 4'b0000);             // P70
        adv(14);                                // P84
        check_disp("ovw_d0", 4'b1110, 8'hA4);
        adv(4);                                 // P88
        check_disp("ovw_d1", 4'b1101, 8'hA4);

        // Load coincident with boundary while idle
        adv(11);                                // P99
        do_load(16'h5678, 4'b0000);             // P100 boundary
        check_disp("bnd_idle_d0", 4'b1110, 8'hA4);
        check("bnd_idle_busy", 16'(busy), 16'h1);
        adv(16);                                // P116
        check_disp("bnd_idle_next", 4'b1110, 8'h80);
        check("bnd_idle_busy_clr", 16'(busy), 16'h0);

        // Load coincident with boundary while busy
        do_load(16'h9999, 4'b0000);             // P117
        adv(14);                                // P131
        do_load(16'h3333, 4'b0000);             // P132 boundary
        check_disp("bnd_busy_d0", 4'b1110, 8'h90);
        check("bnd_busy_busy", 16'(busy), 16'h1);
        adv(16);                                // P148
        check_disp("bnd_busy_next", 4'b1110, 8'hB0);
        check("bnd_busy_clr", 16'(busy), 16'h0);

        // Leading-zero handling and decimal point
        do_load(16'h00E5, 4'b0100);             // P149
        adv(15);                                // P164
        check_disp("lz_d0", 4'b1110, 8'h92);
        adv(4);
        check_disp("lz_d1", 4'b1101, 8'h86);
        adv(4);
`ifdef SSEG_LZ_BLANK_EN
        check_disp("lz_d2", 4'b1011, 8'h7F);
        adv(4);
        check_disp("lz_d3", 4'b0111, 8'hFF);
`else
        check_disp("lz_d2", 4'b1011, 8'h40);
        adv(4);
        check_disp("lz_d3", 4'b0111, 8'hC0);
`endif

        // Reset mid-operation discards pending value
        adv(2);
        do_load(16'h7777, 4'b1111);
        check("pre_rst_busy", 16'(busy), 16'h1);
        reset = 1'b1;
        #1;
        check_disp("midrst", 4'hF, 8'hFF);
        check("midrst_busy", 16'(busy), 16'h0);
        adv(2);
        reset = 1'b0;
        adv(3);
        check_disp("midrst_pre_tick", 4'hF, 8'hFF);
        adv(1);
        check_disp("midrst_tick", 4'b1110, 8'hC0);
        adv(16);
        check_disp("midrst_frame2", 4'b1110, 8'hC0);
        check("midrst_busy2", 16'(busy), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
